// File: rtl/priority_arbiter_7seg.sv
// Eight-requester arbiter with hold timeout and 7-segment display of the granted index.
// Optional macro ROUND_ROBIN_EN selects rotating priority; otherwise bit 7 always wins.
module priority_arbiter_7seg #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic       gnt_valid,
    output logic [2:0] gnt_idx,
    output logic       timeout,
    output logic [6:0] segments,
    output logic       no_grant
);
    localparam int CW = $clog2(MAX_HOLD);
    localparam logic [CW-1:0] LAST = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] hold_cnt;
    logic [2:0]    win_idx;
    logic          win_any;
    logic          rel_norm, rel_force;

    function automatic logic [6:0] seg7(input logic [2:0] d);
        case (d)
            3'd0:    seg7 = 7'b0111111;
            3'd1:    seg7 = 7'b0000110;
            3'd2:    seg7 = 7'b1011011;
            3'd3:    seg7 = 7'b1001111;
            3'd4:    seg7 = 7'b1100110;
            3'd5:    seg7 = 7'b1101101;
            3'd6:    seg7 = 7'b1111101;
            default: seg7 = 7'b0000111;
        endcase
    endfunction

`ifdef ROUND_ROBIN_EN
    logic [2:0] rr_ptr;

    // Search starts just below the last winner and wraps, ending on the last winner itself.
    always_comb begin
        win_idx = 3'd0;
        win_any = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!win_any && req[rr_ptr - 3'(i + 1)]) begin
                win_idx = rr_ptr - 3'(i + 1);
                win_any = 1'b1;
            end
        end
    end
`else
    always_comb begin
        win_idx = 3'd0;
        win_any = |req;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) win_idx = 3'(i);
        end
    end
`endif

    assign rel_norm  = !req[gnt_idx];
    assign rel_force = (hold_cnt == LAST);
    assign gnt_valid = |gnt;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (win_any) state_nx = GRANT;
            GRANT:   if (rel_norm || rel_force) state_nx = RELEASE;
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= 8'd0;
            gnt_idx  <= 3'd0;
            timeout  <= 1'b0;
            segments <= 7'd0;
            no_grant <= 1'b1;
            hold_cnt <= '0;
`ifdef ROUND_ROBIN_EN
            rr_ptr   <= 3'd0;
`endif
        end else begin
            state   <= state_nx;
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        gnt      <= 8'(1) << win_idx;
                        gnt_idx  <= win_idx;
                        segments <= seg7(win_idx);
                        no_grant <= 1'b0;
                        hold_cnt <= '0;
`ifdef ROUND_ROBIN_EN
                        rr_ptr   <= win_idx;
`endif
                    end
                end
                GRANT: begin
                    if (hold_cnt != LAST) hold_cnt <= hold_cnt + 1'b1;
                    if (rel_norm || rel_force) begin
                        gnt      <= 8'd0;
                        gnt_idx  <= 3'd0;
                        segments <= 7'd0;
                        no_grant <= 1'b1;
                        // A simultaneous drop of the request counts as a normal release.
                        timeout  <= !rel_norm;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_priority_arbiter_7seg.sv
// Randomized self-checking bench for priority_arbiter_7seg against an owner/cooldown model.
module tb_priority_arbiter_7seg;
    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'd0;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic       timeout;
    logic [6:0] segments;
    logic       no_grant;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns the resource, how long, and the enforced idle gap.
    int owner = -1;
    int held  = 0;
    int cool  = 0;
    bit to_exp = 1'b0;
    int last  = 0;

    logic [6:0] seg_tab [8] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111};

    priority_arbiter_7seg #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .gnt_valid(gnt_valid),
        .gnt_idx(gnt_idx), .timeout(timeout), .segments(segments), .no_grant(no_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] r);
`ifdef ROUND_ROBIN_EN
        for (int i = 1; i <= 8; i++) begin
            int c = (last - i + 16) % 8;
            if (r[c]) return c;
        end
        return 0;
`else
        for (int i = 7; i >= 0; i--) if (r[i]) return i;
        return 0;
`endif
    endfunction

    task automatic model(input logic [7:0] r, input logic rn);
        if (!rn) begin
            owner = -1; held = 0; cool = 0; to_exp = 0; last = 0;
        end else begin
            to_exp = 0;
            if (owner >= 0) begin
                held++;
                if (!r[owner]) begin
                    owner = -1; cool = 1;
                end else if (held == MAX_HOLD) begin
                    owner = -1; cool = 1; to_exp = 1;
                end
            end else if (cool > 0) begin
                cool--;
            end else if (r != 8'd0) begin
                owner = pick(r); held = 0; last = owner;
            end
        end
    endtask

    task automatic step(input logic [7:0] r, input logic rn);
        logic [7:0] eg;
        req = r;
        rst_n = rn;
        @(posedge clk);
        model(r, rn);
        #1;
        eg = (owner >= 0) ? (8'd1 << owner) : 8'd0;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("gnt_valid", 32'(gnt_valid), 32'(owner >= 0));
        chk("gnt_idx", 32'(gnt_idx), (owner >= 0) ? 32'(owner) : 32'd0);
        chk("timeout", 32'(timeout), 32'(to_exp));
        chk("segments", 32'(segments), (owner >= 0) ? 32'(seg_tab[owner]) : 32'd0);
        chk("no_grant", 32'(no_grant), 32'(owner < 0));
    endtask

    task automatic hold(input logic [7:0] r, input int n);
        for (int i = 0; i < n; i++) step(r, 1'b1);
    endtask

    initial begin
        logic [7:0] rv;
        step(8'd0, 1'b0);
        step(8'd0, 1'b0);
        // Explicit reset-state values, independent of the model.
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_seg", 32'(segments), 32'd0);
        chk("rst_dp", 32'(no_grant), 32'd1);
        hold(8'd0, 3);
        // Fixed-priority example, then drop the winner.
        step(8'b0010_0101, 1'b1);
        chk("fp_idx5", 32'(gnt_idx), 32'd5);
        chk("fp_seg5", 32'(segments), 32'b1101101);
        hold(8'b0010_0101, 2);
        hold(8'b0000_0101, 6);
        hold(8'd0, 3);
        // Forced release with a held request.
        hold(8'h80, 14);
        hold(8'd0, 3);
        // Round-robin style pattern: rotating or repeated bit 7 depending on build.
        hold(8'b1000_1001, 24);
        hold(8'd0, 3);
        // No pre-emption of idx 1 by idx 7.
        hold(8'h02, 2);
        hold(8'h82, 2);
        chk("nopre", 32'(gnt), 32'h02);
        hold(8'h80, 6);
        hold(8'd0, 3);
        // Reset mid-grant.
        hold(8'h10, 2);
        step(8'h10, 1'b0);
        chk("mid_rst_to", 32'(timeout), 32'd0);
        hold(8'hff, 8);
        hold(8'd0, 3);
        // Randomized level requests held for random stretches, with rare resets.
        rv = 8'd0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) == 0)
                rv = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
            step(rv, ($urandom_range(0, 99) != 0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
